// File: rtl/hazard_pkg.sv
// hazard_pkg: definitions shared by the hazard control unit and its bench.
//   state_e    : load-stall FSM encoding (IDLE=0, LOAD_WAIT=1)
//   REG_W_MAX  : widest register index reg_match() accepts; callers zero-extend
//   REG_ZERO   : architectural zero register, which never creates a hazard
//   STALL_CW   : width of the load-stall down-counter (covers 1..7 cycles)
//   reg_match(): an operand depends on rd only if it is read and is not r0
package hazard_pkg;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_e;

  localparam int                   REG_W_MAX = 8;
  localparam logic [REG_W_MAX-1:0] REG_ZERO  = '0;
  localparam int                   STALL_CW  = 3;

  function automatic logic reg_match(input logic [REG_W_MAX-1:0] idx,
                                     input logic                 use_f,
                                     input logic [REG_W_MAX-1:0] rd);
    return use_f && (idx != REG_ZERO) && (idx == rd);
  endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// hazard_control_unit_if: pipeline-side signals of the hazard control unit.
//   master : pipeline/debug side, drives the i_* hazard inputs, reads o_*
//   slave  : hazard unit side, reads i_*, drives stall/flush/redirect and
//            the statistics counters
// Clock and reset are not part of the bundle.
interface hazard_control_unit_if #(
  parameter int N_BITS     = 32,
  parameter int N_BITS_REG = 5,
  parameter int CNT_BITS   = 16
);
  logic                  i_enable;
  logic [N_BITS_REG-1:0] i_rs;
  logic [N_BITS_REG-1:0] i_rt;
  logic                  i_uses_rs;
  logic                  i_uses_rt;
  logic                  i_memRead_ID_EX;
  logic                  i_regWrite_ID_EX;
  logic [N_BITS_REG-1:0] i_ID_EX_rd;
  logic                  i_regWrite_EX_MEM;
  logic                  i_memRead_EX_MEM;
  logic [N_BITS_REG-1:0] i_EX_MEM_rd;
  logic                  i_PCSrc_ID;
  logic [N_BITS-1:0]     i_jump_direction_ID;
  logic                  i_PCSrc_EX;
  logic [N_BITS-1:0]     i_jump_direction_EX;

  logic                  o_stall;
  logic                  o_bubble_ID_EX;
  logic                  o_flush_IF_ID;
  logic                  o_flush_ID_EX;
  logic                  o_PCSrc;
  logic [N_BITS-1:0]     o_jump_direction;
  logic [CNT_BITS-1:0]   o_stall_count;
  logic [CNT_BITS-1:0]   o_flush_count;

  modport master (
    output i_enable, i_rs, i_rt, i_uses_rs, i_uses_rt,
           i_memRead_ID_EX, i_regWrite_ID_EX, i_ID_EX_rd,
           i_regWrite_EX_MEM, i_memRead_EX_MEM, i_EX_MEM_rd,
           i_PCSrc_ID, i_jump_direction_ID, i_PCSrc_EX, i_jump_direction_EX,
    input  o_stall, o_bubble_ID_EX, o_flush_IF_ID, o_flush_ID_EX,
           o_PCSrc, o_jump_direction, o_stall_count, o_flush_count
  );

  modport slave (
    input  i_enable, i_rs, i_rt, i_uses_rs, i_uses_rt,
           i_memRead_ID_EX, i_regWrite_ID_EX, i_ID_EX_rd,
           i_regWrite_EX_MEM, i_memRead_EX_MEM, i_EX_MEM_rd,
           i_PCSrc_ID, i_jump_direction_ID, i_PCSrc_EX, i_jump_direction_EX,
    output o_stall, o_bubble_ID_EX, o_flush_IF_ID, o_flush_ID_EX,
           o_PCSrc, o_jump_direction, o_stall_count, o_flush_count
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: saturating event counter.
//   clk    : rising-edge clock
//   reset  : synchronous, active-high clear
//   enable : counting allowed this cycle
//   inc    : event to count
//   count  : current value, sticks at all-ones
module sat_counter #(
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                inc,
  output logic [CNT_BITS-1:0] count
);

  logic [CNT_BITS-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (enable && inc && (count_q != '1))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: hazard detection and redirect control for the 5-stage
// MIPS pipeline, between ID and the IF/ID, ID/EX and PC registers.
//   i_clk, i_reset : clock, synchronous active-high reset
//   hz (slave)     : ID operands, EX/MEM destination info, ID/EX redirects in;
//                    stall, bubble, flushes, PC redirect and counters out
// Controls are combinational so they act in the cycle the hazard is seen.
// Priority: EX redirect > load stall > branch-operand stall > ID redirect.
// A load holds the pipe LOAD_STALL_CYCLES cycles: the first is the ld_use
// cycle itself, the rest are spent in LOAD_WAIT.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int N_BITS            = 32,
  parameter int N_BITS_REG        = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_BITS          = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  hazard_control_unit_if.slave  hz
);

  localparam logic [STALL_CW-1:0] LOAD_CNT = STALL_CW'(LOAD_STALL_CYCLES - 1);

  state_e              state_q, state_d;
  logic [STALL_CW-1:0] cnt_q, cnt_d;
  logic [N_BITS-1:0]   jump_q, jump_d;

  logic rs_hit_ex, rt_hit_ex, rs_hit_mem, rt_hit_mem;
  logic ld_use, br_dep, ex_redir, load_stall;

  logic              stall_c, bubble_c, flush_if_id_c, flush_id_ex_c, pcsrc_c;
  logic [N_BITS-1:0] jump_c;

  // An ALU result in EX/MEM is forwarded to the branch comparator, so the
  // MEM-stage write enable plays no part in hazard detection.
  logic unused_rw_ex_mem;
  assign unused_rw_ex_mem = hz.i_regWrite_EX_MEM;

  // ---------------------------------------------------------------- hazards
  always_comb begin
    rs_hit_ex  = reg_match(REG_W_MAX'(hz.i_rs), hz.i_uses_rs, REG_W_MAX'(hz.i_ID_EX_rd));
    rt_hit_ex  = reg_match(REG_W_MAX'(hz.i_rt), hz.i_uses_rt, REG_W_MAX'(hz.i_ID_EX_rd));
    rs_hit_mem = reg_match(REG_W_MAX'(hz.i_rs), hz.i_uses_rs, REG_W_MAX'(hz.i_EX_MEM_rd));
    rt_hit_mem = reg_match(REG_W_MAX'(hz.i_rt), hz.i_uses_rt, REG_W_MAX'(hz.i_EX_MEM_rd));

    ld_use   = hz.i_memRead_ID_EX && (rs_hit_ex || rt_hit_ex);
    // Branches compare in ID: they must wait for a result still in EX, or for
    // load data that is only available at the end of MEM.
    br_dep   = hz.i_PCSrc_ID &&
               ((hz.i_regWrite_ID_EX && (rs_hit_ex || rt_hit_ex)) ||
                (hz.i_memRead_EX_MEM && (rs_hit_mem || rt_hit_mem)));
    ex_redir = hz.i_PCSrc_EX;
    load_stall = (state_q == LOAD_WAIT) || ld_use;
  end

  // --------------------------------------------------------------- controls
  always_comb begin
    stall_c       = 1'b0;
    bubble_c      = 1'b0;
    flush_if_id_c = 1'b0;
    flush_id_ex_c = 1'b0;
    pcsrc_c       = 1'b0;
    jump_c        = jump_q;
    if (i_reset) begin
      jump_c = '0;
    end else if (hz.i_enable) begin
      if (ex_redir) begin
        // Both younger instructions are on the wrong path, including one
        // that was being held by a load stall.
        pcsrc_c       = 1'b1;
        jump_c        = hz.i_jump_direction_EX;
        flush_if_id_c = 1'b1;
        flush_id_ex_c = 1'b1;
      end else if (load_stall || br_dep) begin
        stall_c  = 1'b1;
        bubble_c = 1'b1;
      end else if (hz.i_PCSrc_ID) begin
        pcsrc_c       = 1'b1;
        jump_c        = hz.i_jump_direction_ID;
        flush_if_id_c = 1'b1;
      end
    end
  end

  assign jump_d = jump_c;

  // -------------------------------------------------------------------- FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (ld_use && !ex_redir && (LOAD_STALL_CYCLES > 1)) begin
          state_d = LOAD_WAIT;
          cnt_d   = LOAD_CNT;
        end
      end
      LOAD_WAIT: begin
        // cnt_q counts the stall cycles still owed including this one.
        if (ex_redir || (cnt_q <= STALL_CW'(1))) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      jump_q  <= '0;
    end else if (hz.i_enable) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      jump_q  <= jump_d;
    end
  end

  // -------------------------------------------------------------- statistics
  sat_counter #(.CNT_BITS(CNT_BITS)) u_stall_cnt (
    .clk    (i_clk),
    .reset  (i_reset),
    .enable (hz.i_enable),
    .inc    (stall_c),
    .count  (hz.o_stall_count)
  );

  sat_counter #(.CNT_BITS(CNT_BITS)) u_flush_cnt (
    .clk    (i_clk),
    .reset  (i_reset),
    .enable (hz.i_enable),
    .inc    (pcsrc_c),
    .count  (hz.o_flush_count)
  );

  assign hz.o_stall          = stall_c;
  assign hz.o_bubble_ID_EX   = bubble_c;
  assign hz.o_flush_IF_ID    = flush_if_id_c;
  assign hz.o_flush_ID_EX    = flush_id_ex_c;
  assign hz.o_PCSrc          = pcsrc_c;
  assign hz.o_jump_direction = jump_c;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Two instances share stimulus: dut1 (1-cycle load, 16-bit counters) and
// dut3 (3-cycle load, 4-bit counters). A reference model keeps, per
// instance, the number of stall cycles still owed by a load plus the counters.
module tb_hazard_control_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  hazard_control_unit_if #(.N_BITS(32), .N_BITS_REG(5), .CNT_BITS(16)) if1();
  hazard_control_unit_if #(.N_BITS(32), .N_BITS_REG(5), .CNT_BITS(4))  if3();

  hazard_control_unit #(.N_BITS(32), .N_BITS_REG(5), .LOAD_STALL_CYCLES(1), .CNT_BITS(16))
    dut1 (.i_clk(clk), .i_reset(rst), .hz(if1.slave));
  hazard_control_unit #(.N_BITS(32), .N_BITS_REG(5), .LOAD_STALL_CYCLES(3), .CNT_BITS(4))
    dut3 (.i_clk(clk), .i_reset(rst), .hz(if3.slave));

  typedef struct packed {
    logic rst, en;
    logic [4:0] rs, rt;
    logic urs, urt, mr_ex, rw_ex;
    logic [4:0] rd_ex;
    logic rw_mem, mr_mem;
    logic [4:0] rd_mem;
    logic pcid;
    logic [31:0] jid;
    logic pcex;
    logic [31:0] jex;
  } stim_t;

  typedef struct packed {
    logic stall, bub, fif, fie, pc;
    logic [31:0] jd;
    logic [15:0] sc, fc;
  } obs_t;

  stim_t cur;
  int n_vec = 0, n_err = 0;

  // ---------------------------------------------------------------- model
  int L[2]    = '{1, 3};
  int cmax[2] = '{65535, 15};
  int rem[2], sc[2], fc[2];
  logic [31:0] jl[2];

  function automatic bit hit(logic [4:0] idx, logic u, logic [4:0] rd);
    return u && idx != 0 && idx == rd;
  endfunction

  function automatic bit m_ld_use(stim_t s);
    return s.mr_ex && (hit(s.rs, s.urs, s.rd_ex) || hit(s.rt, s.urt, s.rd_ex));
  endfunction

  function automatic obs_t model_out(int k, stim_t s);
    obs_t o;
    bit hx, hm, bd;
    o = '0;
    o.sc = 16'(sc[k]);
    o.fc = 16'(fc[k]);
    hx = hit(s.rs, s.urs, s.rd_ex)  || hit(s.rt, s.urt, s.rd_ex);
    hm = hit(s.rs, s.urs, s.rd_mem) || hit(s.rt, s.urt, s.rd_mem);
    bd = s.pcid && ((s.rw_ex && hx) || (s.mr_mem && hm));
    if (s.rst) o.jd = '0;
    else if (!s.en) o.jd = jl[k];
    else if (s.pcex) begin o.pc = 1; o.jd = s.jex; o.fif = 1; o.fie = 1; end
    else if (rem[k] > 0 || m_ld_use(s) || bd) begin o.stall = 1; o.bub = 1; o.jd = jl[k]; end
    else if (s.pcid) begin o.pc = 1; o.jd = s.jid; o.fif = 1; end
    else o.jd = jl[k];
    return o;
  endfunction

  task automatic model_step(stim_t s);
    for (int k = 0; k < 2; k++) begin
      obs_t o;
      o = model_out(k, s);
      if (s.rst) begin
        rem[k] = 0; sc[k] = 0; fc[k] = 0; jl[k] = '0;
      end else if (s.en) begin
        if (s.pcex) rem[k] = 0;
        else if (rem[k] > 0) rem[k] = rem[k] - 1;
        else if (m_ld_use(s)) rem[k] = L[k] - 1;
        if (o.stall && sc[k] < cmax[k]) sc[k]++;
        if (o.pc && fc[k] < cmax[k]) fc[k]++;
        jl[k] = o.jd;
      end
    end
  endtask

  function automatic obs_t got(int k);
    if (k == 0)
      return {if1.o_stall, if1.o_bubble_ID_EX, if1.o_flush_IF_ID, if1.o_flush_ID_EX,
              if1.o_PCSrc, if1.o_jump_direction, if1.o_stall_count, if1.o_flush_count};
    return {if3.o_stall, if3.o_bubble_ID_EX, if3.o_flush_IF_ID, if3.o_flush_ID_EX,
            if3.o_PCSrc, if3.o_jump_direction, 16'(if3.o_stall_count), 16'(if3.o_flush_count)};
  endfunction

  // ------------------------------------------------------------ stimulus
  function automatic stim_t idle_s();
    stim_t s;
    s = '0;
    s.en = 1'b1;
    return s;
  endfunction

  task automatic settle(stim_t s);
    cur = s;
    rst = s.rst;
    if1.i_enable = s.en;            if3.i_enable = s.en;
    if1.i_rs = s.rs;                if3.i_rs = s.rs;
    if1.i_rt = s.rt;                if3.i_rt = s.rt;
    if1.i_uses_rs = s.urs;          if3.i_uses_rs = s.urs;
    if1.i_uses_rt = s.urt;          if3.i_uses_rt = s.urt;
    if1.i_memRead_ID_EX = s.mr_ex;  if3.i_memRead_ID_EX = s.mr_ex;
    if1.i_regWrite_ID_EX = s.rw_ex; if3.i_regWrite_ID_EX = s.rw_ex;
    if1.i_ID_EX_rd = s.rd_ex;       if3.i_ID_EX_rd = s.rd_ex;
    if1.i_regWrite_EX_MEM = s.rw_mem; if3.i_regWrite_EX_MEM = s.rw_mem;
    if1.i_memRead_EX_MEM = s.mr_mem;  if3.i_memRead_EX_MEM = s.mr_mem;
    if1.i_EX_MEM_rd = s.rd_mem;     if3.i_EX_MEM_rd = s.rd_mem;
    if1.i_PCSrc_ID = s.pcid;        if3.i_PCSrc_ID = s.pcid;
    if1.i_jump_direction_ID = s.jid; if3.i_jump_direction_ID = s.jid;
    if1.i_PCSrc_EX = s.pcex;        if3.i_PCSrc_EX = s.pcex;
    if1.i_jump_direction_EX = s.jex; if3.i_jump_direction_EX = s.jex;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(cur);
    #1;
  endtask

  function automatic stim_t load_use_s();
    stim_t s;
    s = idle_s();
    s.mr_ex = 1; s.rd_ex = 5; s.rs = 5; s.urs = 1;
    return s;
  endfunction

  // --------------------------------------------------------------- tests
  task automatic test_reset();
    stim_t s;
    s = idle_s();
    s.rst = 1; s.pcid = 1; s.jid = 32'h44;
    settle(s);
    n_vec++;
    if ({if1.o_stall, if1.o_bubble_ID_EX, if1.o_flush_IF_ID, if1.o_flush_ID_EX, if1.o_PCSrc,
         if1.o_jump_direction, if1.o_stall_count, if1.o_flush_count} !== '0) begin
      n_err++; $display("FAIL reset_outputs got stall=%b pc=%b jd=%h sc=%0d", if1.o_stall,
                        if1.o_PCSrc, if1.o_jump_direction, if1.o_stall_count);
    end
    tick();
    settle(idle_s());
    for (int k = 0; k < 2; k++) begin
      obs_t g, e;
      g = got(k); e = model_out(k, cur); n_vec++;
      if (g !== e) begin n_err++; $display("FAIL reset_idle dut%0d got=%h exp=%h", k, g, e); end
    end
    tick();
  endtask

  task automatic test_load_use();
    int nst[2];
    stim_t s;
    nst = '{0, 0};
    for (int c = 0; c < 5; c++) begin
      s = (c == 0) ? load_use_s() : idle_s();
      settle(s);
      for (int k = 0; k < 2; k++) begin
        obs_t g, e;
        g = got(k); e = model_out(k, cur); n_vec++;
        if (g !== e) begin n_err++; $display("FAIL load_use dut%0d cyc%0d got=%h exp=%h", k, c, g, e); end
        if (g.stall && g.bub) nst[k]++;
      end
      tick();
    end
    settle(idle_s());
    n_vec++;
    if (nst[0] != 1 || if1.o_stall_count !== 16'd1) begin
      n_err++; $display("FAIL load_len1 got %0d cycles cnt %0d, need 1/1", nst[0], if1.o_stall_count);
    end
    n_vec++;
    if (nst[1] != 3 || if3.o_stall_count !== 4'd3) begin
      n_err++; $display("FAIL load_len3 got %0d cycles cnt %0d, need 3/3", nst[1], if3.o_stall_count);
    end
    tick();
    s = load_use_s();
    s.rs = 0; s.rd_ex = 0;
    settle(s);
    n_vec++;
    if (if1.o_stall !== 1'b0 || if3.o_stall !== 1'b0) begin
      n_err++; $display("FAIL r0_no_hazard got %b/%b need 0/0", if1.o_stall, if3.o_stall);
    end
    tick();
  endtask

  task automatic test_branch_dep();
    stim_t s;
    s = idle_s();
    s.pcid = 1; s.jid = 32'h40; s.rs = 8; s.urs = 1; s.rw_ex = 1; s.rd_ex = 8;
    settle(s);
    n_vec++;
    if (if1.o_stall !== 1'b1 || if1.o_bubble_ID_EX !== 1'b1 || if1.o_PCSrc !== 1'b0) begin
      n_err++; $display("FAIL br_dep_stall got stall=%b pc=%b need 1/0", if1.o_stall, if1.o_PCSrc);
    end
    tick();
    s.rd_ex = 9;
    settle(s);
    n_vec++;
    if (if1.o_PCSrc !== 1'b1 || if1.o_jump_direction !== 32'h40 || if1.o_flush_IF_ID !== 1'b1 ||
        if1.o_flush_ID_EX !== 1'b0 || if1.o_stall !== 1'b0) begin
      n_err++; $display("FAIL br_redirect got pc=%b jd=%h fif=%b need 1/40/1", if1.o_PCSrc,
                        if1.o_jump_direction, if1.o_flush_IF_ID);
    end
    tick();
    // load in MEM feeding the branch stalls; ALU result in MEM does not
    for (int c = 0; c < 2; c++) begin
      s = idle_s();
      s.pcid = 1; s.jid = 32'h80; s.rt = 7; s.urt = 1; s.rd_mem = 7;
      s.mr_mem = (c == 0); s.rw_mem = 1;
      settle(s);
      for (int k = 0; k < 2; k++) begin
        obs_t g, e;
        g = got(k); e = model_out(k, cur); n_vec++;
        if (g !== e) begin n_err++; $display("FAIL br_mem dut%0d cyc%0d got=%h exp=%h", k, c, g, e); end
      end
      tick();
    end
  endtask

  task automatic test_ex_redirect();
    stim_t s;
    int fc_snap;
    settle(load_use_s());
    tick();
    fc_snap = fc[1];
    s = idle_s();
    s.pcex = 1; s.jex = 32'h100;
    settle(s);
    n_vec++;
    if (if3.o_PCSrc !== 1'b1 || if3.o_jump_direction !== 32'h100 || if3.o_flush_IF_ID !== 1'b1 ||
        if3.o_flush_ID_EX !== 1'b1 || if3.o_stall !== 1'b0) begin
      n_err++; $display("FAIL ex_redirect got pc=%b jd=%h stall=%b need 1/100/0", if3.o_PCSrc,
                        if3.o_jump_direction, if3.o_stall);
    end
    tick();
    settle(idle_s());
    n_vec++;
    if (if3.o_stall !== 1'b0 || if3.o_flush_count !== 4'(fc_snap + 1)) begin
      n_err++; $display("FAIL ex_abort got stall=%b fc=%0d need 0/%0d", if3.o_stall,
                        if3.o_flush_count, fc_snap + 1);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    stim_t s;
    settle(load_use_s());
    tick();
    s = idle_s();
    s.rst = 1;
    settle(s);
    n_vec++;
    if (if3.o_stall !== 1'b0 || if3.o_bubble_ID_EX !== 1'b0 || if3.o_jump_direction !== 32'h0) begin
      n_err++; $display("FAIL reset_mid_out got stall=%b jd=%h need 0/0", if3.o_stall, if3.o_jump_direction);
    end
    tick();
    settle(idle_s());
    n_vec++;
    if (if3.o_stall !== 1'b0 || if3.o_stall_count !== 4'd0 || if3.o_flush_count !== 4'd0 ||
        if3.o_jump_direction !== 32'h0) begin
      n_err++; $display("FAIL reset_mid_after got stall=%b sc=%0d fc=%0d need 0/0/0", if3.o_stall,
                        if3.o_stall_count, if3.o_flush_count);
    end
    tick();
  endtask

  task automatic test_saturate();
    stim_t s;
    for (int c = 0; c < 20; c++) begin
      settle(load_use_s());
      for (int k = 0; k < 2; k++) begin
        obs_t g, e;
        g = got(k); e = model_out(k, cur); n_vec++;
        if (g !== e) begin n_err++; $display("FAIL saturate dut%0d cyc%0d got=%h exp=%h", k, c, g, e); end
      end
      tick();
    end
    s = load_use_s();
    s.en = 0;
    for (int c = 0; c < 3; c++) begin
      settle(s);
      n_vec++;
      if (if3.o_stall_count !== 4'd15 || if3.o_stall !== 1'b0 || if1.o_stall !== 1'b0) begin
        n_err++; $display("FAIL sat_hold cyc%0d got cnt=%0d stall=%b need 15/0", c,
                          if3.o_stall_count, if3.o_stall);
      end
      tick();
    end
  endtask

  task automatic test_random();
    stim_t s;
    for (int c = 0; c < 400; c++) begin
      s = idle_s();
      s.rst    = ($urandom_range(0, 39) == 0);
      s.en     = ($urandom_range(0, 9) != 0);
      s.rs     = 5'($urandom_range(0, 3));
      s.rt     = 5'($urandom_range(0, 3));
      s.urs    = 1'($urandom_range(0, 1));
      s.urt    = 1'($urandom_range(0, 1));
      s.mr_ex  = 1'($urandom_range(0, 1));
      s.rw_ex  = 1'($urandom_range(0, 1));
      s.rd_ex  = 5'($urandom_range(0, 3));
      s.rw_mem = 1'($urandom_range(0, 1));
      s.mr_mem = 1'($urandom_range(0, 1));
      s.rd_mem = 5'($urandom_range(0, 3));
      s.pcid   = ($urandom_range(0, 3) == 0);
      s.jid    = $urandom;
      s.pcex   = ($urandom_range(0, 7) == 0);
      s.jex    = $urandom;
      settle(s);
      for (int k = 0; k < 2; k++) begin
        obs_t g, e;
        g = got(k); e = model_out(k, cur); n_vec++;
        if (g !== e) begin n_err++; $display("FAIL random dut%0d cyc%0d got=%h exp=%h", k, c, g, e); end
      end
      tick();
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rem[k] = 0; sc[k] = 0; fc[k] = 0; jl[k] = '0;
    end
    test_reset();
    test_load_use();
    test_branch_dep();
    test_ex_redirect();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
